// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative RV64 M-extension multiply/divide (1 bit / cycle) |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN   = 64,
  parameter int WORD_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op_in,
  input  logic            word_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic            flush_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out,
  output logic            busy_out
);

  localparam int              c_CNT_W  = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0] c_LAST_X = c_CNT_W'(XLEN - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_W = c_CNT_W'(WORD_W - 1);
  localparam logic [XLEN-1:0] c_MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_MIN_W  = {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] f_sext(input logic [WORD_W-1:0] x);
    return {{(XLEN-WORD_W){x[WORD_W-1]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] f_zext(input logic [WORD_W-1:0] x);
    return {{(XLEN-WORD_W){1'b0}}, x};
  endfunction

  state_t              r_state;
  logic [2:0]          r_op;
  logic                r_word;
  logic                r_neg;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [XLEN-1:0]     r_result;
  logic                r_out_valid;
  logic                r_in_ready;
  logic                r_busy;

  // Operand decode and special-case detection on the request inputs
  logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_dvd_res, w_spec_res;
  logic [2*XLEN-1:0] w_acc_init;

  always_comb begin
    w_is_div   = op_in[2];
    w_a_signed = op_in[2] ? ~op_in[0]
                          : (~word_in & ((op_in[1:0] == 2'b01) | (op_in[1:0] == 2'b10)));
    w_b_signed = op_in[2] ? ~op_in[0] : (~word_in & (op_in[1:0] == 2'b01));
    w_a_ext = word_in ? (w_a_signed ? f_sext(rs1_value_in[WORD_W-1:0])
                                    : f_zext(rs1_value_in[WORD_W-1:0])) : rs1_value_in;
    w_b_ext = word_in ? (w_b_signed ? f_sext(rs2_value_in[WORD_W-1:0])
                                    : f_zext(rs2_value_in[WORD_W-1:0])) : rs2_value_in;
    w_a_neg = w_a_signed & w_a_ext[XLEN-1];
    w_b_neg = w_b_signed & w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_neg   = (w_is_div & op_in[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_min   = word_in ? c_MIN_W : c_MIN_X;
    w_div0  = w_is_div & (w_b_ext == '0);
    w_ovf   = w_is_div & ~op_in[0] & (w_a_ext == w_min) & (w_b_ext == '1);
    w_special = w_div0 | w_ovf;
    w_dvd_res = word_in ? f_sext(rs1_value_in[WORD_W-1:0]) : rs1_value_in;
    w_spec_res = w_div0 ? (op_in[1] ? w_dvd_res : '1) : (op_in[1] ? '0 : w_dvd_res);
    // W divides start with the dividend pre-aligned so only WORD_W steps are needed
    if (w_is_div) begin
      w_acc_init = word_in ? {{XLEN{1'b0}}, w_a_mag[WORD_W-1:0], {(XLEN-WORD_W){1'b0}}}
                           : {{XLEN{1'b0}}, w_a_mag};
    end else begin
      w_acc_init = {{XLEN{1'b0}}, w_b_mag};
    end
  end

  // One shift-add or one restoring-subtract step on the accumulator
  logic [XLEN:0]     w_mul_sum, w_rem_sh, w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod;
  logic [XLEN-1:0]   w_mul_res, w_div_sel, w_div_fix, w_div_res, w_final;

  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_diff     = w_rem_sh - {1'b0, r_opnd};
    w_ge       = ~w_diff[XLEN];
    w_div_next = {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

    // After WORD_W steps the low product word sits at [XLEN-1:XLEN-WORD_W]
    w_prod    = r_neg ? -w_mul_next : w_mul_next;
    w_mul_res = r_word ? f_sext(w_prod[XLEN-WORD_W +: WORD_W])
                       : ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    w_div_sel = r_op[1] ? w_div_next[2*XLEN-1:XLEN] : w_div_next[XLEN-1:0];
    w_div_fix = r_neg ? -w_div_sel : w_div_sel;
    w_div_res = r_word ? f_sext(w_div_fix[WORD_W-1:0]) : w_div_fix;
    w_final   = r_op[2] ? w_div_res : w_mul_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_word      <= 1'b0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else if (flush_in) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= op_in;
            r_word     <= word_in;
            r_neg      <= w_neg;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_special) begin
              r_result    <= w_spec_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_acc   <= w_acc_init;
              r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
              r_cnt   <= word_in ? c_LAST_W : c_LAST_X;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign result_out = r_result;
  assign busy_out   = r_busy;

endmodule
`default_nettype wire
